// File: rtl/router_dest_reader_pkg.sv
// rtl/router_dest_reader_pkg.sv - Header layout, FSM states and defaults for the port reader
package router_dest_reader_pkg;
   localparam int LEN_MSB       = 7;
   localparam int LEN_LSB       = 2;
   localparam int ADDR_MSB      = 1;
   localparam int LEN_W         = LEN_MSB - LEN_LSB + 1;
   localparam int ADDR_W        = ADDR_MSB + 1;
   localparam int CNT_W         = LEN_W + 1;
   localparam int GAP_LIMIT_DEF = 30;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_BODY = 2'd2,
      S_END  = 2'd3
   } state_t;

   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [ADDR_W-1:0] addr;
   } hdr_t;
endpackage

// File: rtl/router_dest_reader_if.sv
// rtl/router_dest_reader_if.sv - FIFO read side, payload sink and packet status bundle
interface router_dest_reader_if;
   import router_dest_reader_pkg::*;

   logic              enable;
   logic              vld_out;
   logic [7:0]        data_in;
   logic              read_enb;
   logic              sink_ready;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              pkt_done;
   logic [ADDR_W-1:0] pkt_addr;
   logic [LEN_W-1:0]  pkt_len;
   logic              parity_err;
   logic              addr_err;
   logic              hdr_err;
   logic              timeout;
   logic              busy;

   modport master (
      input  enable, vld_out, data_in, sink_ready,
      output read_enb, byte_valid, byte_data, pkt_done, pkt_addr, pkt_len,
             parity_err, addr_err, hdr_err, timeout, busy
   );

   modport slave (
      output enable, vld_out, data_in, sink_ready,
      input  read_enb, byte_valid, byte_data, pkt_done, pkt_addr, pkt_len,
             parity_err, addr_err, hdr_err, timeout, busy
   );
endinterface

// File: rtl/router_gap_timer.sv
// rtl/router_gap_timer.sv - Counts idle cycles mid-packet and pulses when the limit is hit
module router_gap_timer #(
   parameter int LIMIT = 30
) (
   input  logic clock,
   input  logic resetn,
   input  logic clear,
   input  logic count_en,
   output logic expire
);
   localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

   logic [W-1:0] cnt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count_en) begin
         cnt <= cnt + W'(1);
      end
   end

   // Fires on the LIMIT-th consecutive counted cycle, not the one after.
   assign expire = count_en && !clear && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/router_dest_reader.sv
// rtl/router_dest_reader.sv - Drains one router output FIFO, parses header/payload/parity, reports status
module router_dest_reader
   import router_dest_reader_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PORT_ID   = '0,
   parameter int                GAP_LIMIT = GAP_LIMIT_DEF
) (
   input logic                  clock,
   input logic                  resetn,
   router_dest_reader_if.master bus
);
   state_t            state, state_nxt;
   hdr_t              hdr_in, hdr_q;
   logic              rd_pend, read_req, done;
   logic              hdr_err_c, parity_err_c, timeout_c;
   logic [7:0]        acc, parity_q;
   logic [CNT_W-1:0]  req_cnt, rcv_cnt, len_ext;
   logic              payload_rx, parity_rx;
   logic              gap_clear, gap_count, gap_expire;
   logic [ADDR_W-1:0] addr_cur;

   assign hdr_in     = hdr_t'(bus.data_in);
   assign len_ext    = {1'b0, hdr_q.len};
   assign payload_rx = (state == S_BODY) && rd_pend && (rcv_cnt < len_ext);
   assign parity_rx  = (state == S_BODY) && rd_pend && !(rcv_cnt < len_ext);
   assign gap_clear  = (state != S_BODY) || rd_pend;
   assign gap_count  = (state == S_BODY) && !rd_pend;

   router_gap_timer #(.LIMIT(GAP_LIMIT)) u_gap (
      .clock    (clock),
      .resetn   (resetn),
      .clear    (gap_clear),
      .count_en (gap_count),
      .expire   (gap_expire)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      read_req     = 1'b0;
      done         = 1'b0;
      hdr_err_c    = 1'b0;
      parity_err_c = 1'b0;
      timeout_c    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.enable && bus.vld_out) begin
               read_req  = 1'b1;
               state_nxt = S_HDR;
            end
         end
         S_HDR: begin
            if (hdr_in.len == '0) begin
               done      = 1'b1;
               hdr_err_c = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_BODY;
            end
         end
         S_BODY: begin
            // Never launch a read on the abort cycle: its byte would be orphaned.
            read_req = bus.vld_out && bus.sink_ready && !gap_expire &&
                       (req_cnt < len_ext + CNT_W'(1));
            if (parity_rx) begin
               state_nxt = S_END;
            end else if (gap_expire) begin
               done      = 1'b1;
               timeout_c = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_END: begin
            done         = 1'b1;
            parity_err_c = (acc != parity_q);
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // A zero-length header finishes in HDR, before the address is registered.
   assign addr_cur = (state == S_HDR) ? hdr_in.addr : hdr_q.addr;

   assign bus.read_enb   = read_req && resetn;
   assign bus.byte_valid = payload_rx;
   assign bus.byte_data  = payload_rx ? bus.data_in : 8'h00;
   assign bus.pkt_done   = done;
   assign bus.parity_err = parity_err_c;
   assign bus.addr_err   = done && (addr_cur != PORT_ID);
   assign bus.hdr_err    = hdr_err_c;
   assign bus.timeout    = timeout_c;
   assign bus.busy       = (state != S_IDLE);
   assign bus.pkt_addr   = hdr_q.addr;
   assign bus.pkt_len    = hdr_q.len;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_pend  <= 1'b0;
         hdr_q    <= '0;
         acc      <= '0;
         parity_q <= '0;
         req_cnt  <= '0;
         rcv_cnt  <= '0;
      end else begin
         rd_pend <= read_req;
         if (state == S_HDR) begin
            hdr_q <= hdr_in;
            acc   <= bus.data_in;
         end else if (payload_rx) begin
            acc <= acc ^ bus.data_in;
         end
         if (parity_rx) parity_q <= bus.data_in;
         if (state != S_BODY) begin
            req_cnt <= '0;
            rcv_cnt <= '0;
         end else begin
            if (read_req)   req_cnt <= req_cnt + CNT_W'(1);
            if (payload_rx) rcv_cnt <= rcv_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_router_dest_reader.sv
// tb/tb_router_dest_reader.sv - Directed bench for router_dest_reader with a FIFO and sink model
module tb_router_dest_reader;
   logic clock;
   logic resetn;

   router_dest_reader_if bus_if ();

   router_dest_reader #(.PORT_ID(2'd1), .GAP_LIMIT(30)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         reads, done_cnt, ready_viol, empty_viol, stray, last_bv_cyc;
   bit         toggle   = 1'b0;
   bit         ok;
   logic [3:0] flags;
   logic [7:0] fifo[$];
   logic [7:0] got[$];
   int         done_cyc[$];
   int         hdr_reads[$];

   function automatic logic [95:0] got_vec();
      logic [95:0] v;
      v = '0;
      foreach (got[i]) v = {v[87:0], got[i]};
      v[95:88] = 8'(got.size());
      return v;
   endfunction

   function automatic logic [23:0] outs();
      return {bus_if.read_enb, bus_if.byte_valid, bus_if.byte_data, bus_if.pkt_done,
              bus_if.pkt_addr, bus_if.pkt_len, bus_if.parity_err, bus_if.addr_err,
              bus_if.hdr_err, bus_if.timeout, bus_if.busy};
   endfunction

   task automatic clear_stats();
      reads = 0; done_cnt = 0; ready_viol = 0; empty_viol = 0; stray = 0;
      last_bv_cyc = -1; flags = 4'b0;
      got.delete(); done_cyc.delete(); hdr_reads.delete();
   endtask

   // One clock: sample at negedge, then update FIFO/sink inputs just after posedge.
   task automatic tick();
      logic [7:0] nxt;
      logic       have;
      have = 1'b0;
      nxt  = 8'hA5;
      @(negedge clock);
      cyc++;
      if (bus_if.read_enb) begin
         reads++;
         if (!bus_if.busy) hdr_reads.push_back(cyc);
         if (bus_if.busy && !bus_if.sink_ready) ready_viol++;
         if (!bus_if.vld_out || fifo.size() == 0) empty_viol++;
         else begin
            nxt  = fifo.pop_front();
            have = 1'b1;
         end
      end
      if (bus_if.byte_valid) begin
         got.push_back(bus_if.byte_data);
         last_bv_cyc = cyc;
      end
      if (bus_if.pkt_done) begin
         done_cnt++;
         done_cyc.push_back(cyc);
         flags = flags | {bus_if.parity_err, bus_if.addr_err, bus_if.hdr_err, bus_if.timeout};
      end else if (bus_if.parity_err || bus_if.addr_err || bus_if.hdr_err || bus_if.timeout) begin
         stray++;
      end
      @(posedge clock);
      #1;
      bus_if.data_in = have ? nxt : 8'hA5;
      bus_if.vld_out = (fifo.size() != 0);
      if (toggle) bus_if.sink_ready = ~bus_if.sink_ready;
   endtask

   task automatic run(input int ndone, input int budget, output bit done_ok);
      int n;
      n = 0;
      while (done_cnt < ndone && n < budget) begin
         tick();
         n++;
      end
      done_ok = (done_cnt >= ndone);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      bus_if.enable = 1'b1; bus_if.vld_out = 1'b1; bus_if.sink_ready = 1'b1;
      bus_if.data_in = 8'h0D;
      #1 resetn = 1'b0;
      #11;
      n_checks++;
      if (outs() !== 24'h0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 000000", outs());
      end
      bus_if.vld_out = 1'b0;
      @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   task automatic test_good_packet();
      clear_stats();
      fifo = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      bus_if.vld_out = 1'b1;
      run(1, 40, ok);
      idle(3);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL t1_done: done_cnt %0d expected 1", done_cnt); end
      n_checks++;
      if (got_vec() !== {8'd3, 88'h112233}) begin
         n_fail++; $display("FAIL t1_bytes: got %h expected %h", got_vec(), {8'd3, 88'h112233});
      end
      n_checks++;
      if (flags !== 4'b0000) begin n_fail++; $display("FAIL t1_flags: got %b expected 0000", flags); end
      n_checks++;
      if (reads !== 5) begin n_fail++; $display("FAIL t1_reads: got %0d expected 5", reads); end
      n_checks++;
      if ({bus_if.pkt_addr, bus_if.pkt_len} !== {2'd1, 6'd3}) begin
         n_fail++; $display("FAIL t1_hdr: got addr %0d len %0d expected addr 1 len 3",
                            bus_if.pkt_addr, bus_if.pkt_len);
      end
      n_checks++;
      if (empty_viol + stray !== 0) begin
         n_fail++; $display("FAIL t1_protocol: empty reads %0d stray flags %0d expected 0 0",
                            empty_viol, stray);
      end
   endtask

   task automatic test_parity_error();
      clear_stats();
      fifo = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
      bus_if.vld_out = 1'b1;
      run(1, 40, ok);
      idle(2);
      n_checks++;
      if (!ok || flags !== 4'b1000) begin
         n_fail++; $display("FAIL t2_parity: done %0d flags %b expected 1 1000", done_cnt, flags);
      end
      n_checks++;
      if (got_vec() !== {8'd3, 88'h112233}) begin
         n_fail++; $display("FAIL t2_bytes: got %h expected %h", got_vec(), {8'd3, 88'h112233});
      end
   endtask

   task automatic test_zero_len();
      int delta;
      clear_stats();
      fifo = {8'h02};
      bus_if.vld_out = 1'b1;
      run(1, 10, ok);
      idle(2);
      delta = (done_cyc.size() > 0 && hdr_reads.size() > 0) ? done_cyc[0] - hdr_reads[0] : -1;
      n_checks++;
      if (!ok || flags !== 4'b0110) begin
         n_fail++; $display("FAIL t3_flags: done %0d flags %b expected 1 0110", done_cnt, flags);
      end
      n_checks++;
      if (reads !== 1) begin n_fail++; $display("FAIL t3_reads: got %0d expected 1", reads); end
      n_checks++;
      if (delta !== 1) begin n_fail++; $display("FAIL t3_latency: got %0d expected 1", delta); end
      n_checks++;
      if ({bus_if.pkt_addr, bus_if.pkt_len} !== {2'd2, 6'd0}) begin
         n_fail++; $display("FAIL t3_hdr: got addr %0d len %0d expected addr 2 len 0",
                            bus_if.pkt_addr, bus_if.pkt_len);
      end
   endtask

   task automatic test_timeout();
      int delta;
      clear_stats();
      fifo = {8'h11, 8'hAA, 8'hBB};
      bus_if.vld_out = 1'b1;
      run(1, 80, ok);
      delta = (done_cyc.size() > 0) ? done_cyc[0] - last_bv_cyc : -1;
      n_checks++;
      if (!ok || flags !== 4'b0001) begin
         n_fail++; $display("FAIL t4_timeout: done %0d flags %b expected 1 0001", done_cnt, flags);
      end
      n_checks++;
      if (delta !== 30) begin n_fail++; $display("FAIL t4_gap: got %0d expected 30", delta); end
      n_checks++;
      if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy: got %b expected 0", bus_if.busy); end
      n_checks++;
      if (got_vec() !== {8'd2, 88'hAABB}) begin
         n_fail++; $display("FAIL t4_bytes: got %h expected %h", got_vec(), {8'd2, 88'hAABB});
      end
      clear_stats();
      fifo = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      bus_if.vld_out = 1'b1;
      run(1, 40, ok);
      idle(2);
      n_checks++;
      if (!ok || flags !== 4'b0000 || got_vec() !== {8'd3, 88'h112233}) begin
         n_fail++; $display("FAIL t4_recover: done %0d flags %b bytes %h expected 1 0000 %h",
                            done_cnt, flags, got_vec(), {8'd3, 88'h112233});
      end
   endtask

   task automatic test_sink_throttle();
      clear_stats();
      fifo.push_back(8'h29);
      for (int i = 1; i <= 10; i++) fifo.push_back(8'(8'h40 + i));
      fifo.push_back(8'h22);
      bus_if.vld_out = 1'b1;
      toggle = 1'b1;
      run(1, 100, ok);
      toggle = 1'b0;
      bus_if.sink_ready = 1'b1;
      idle(2);
      n_checks++;
      if (!ok || flags !== 4'b0000) begin
         n_fail++; $display("FAIL t5_done: done %0d flags %b expected 1 0000", done_cnt, flags);
      end
      n_checks++;
      if (ready_viol !== 0) begin n_fail++; $display("FAIL t5_ready: got %0d expected 0", ready_viol); end
      n_checks++;
      if (got_vec() !== {8'd10, 88'h4142434445464748494A}) begin
         n_fail++; $display("FAIL t5_bytes: got %h expected %h", got_vec(),
                            {8'd10, 88'h4142434445464748494A});
      end
      n_checks++;
      if (reads !== 12) begin n_fail++; $display("FAIL t5_reads: got %0d expected 12", reads); end
   endtask

   task automatic test_async_reset();
      int n;
      clear_stats();
      fifo = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      bus_if.vld_out = 1'b1;
      n = 0;
      while (got.size() < 1 && n < 20) begin
         tick();
         n++;
      end
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if (outs() !== 24'h0) begin
         n_fail++; $display("FAIL t6_reset_outputs: got %h expected 000000", outs());
      end
      fifo.delete();
      bus_if.vld_out = 1'b0;
      idle(2);
      n_checks++;
      if (done_cnt !== 0 || got.size() !== 1) begin
         n_fail++; $display("FAIL t6_abort: done %0d bytes %0d expected 0 1", done_cnt, got.size());
      end
      #2 resetn = 1'b1;
   endtask

   task automatic test_back_to_back();
      int gap;
      clear_stats();
      fifo = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h09, 8'h5A, 8'hA5, 8'hF6};
      bus_if.vld_out = 1'b1;
      run(2, 60, ok);
      idle(2);
      gap = (hdr_reads.size() > 1 && done_cyc.size() > 0) ? hdr_reads[1] - done_cyc[0] : -1;
      n_checks++;
      if (!ok || flags !== 4'b0000) begin
         n_fail++; $display("FAIL b2b_done: done %0d flags %b expected 2 0000", done_cnt, flags);
      end
      n_checks++;
      if (got_vec() !== {8'd5, 88'h1122335AA5}) begin
         n_fail++; $display("FAIL b2b_bytes: got %h expected %h", got_vec(), {8'd5, 88'h1122335AA5});
      end
      n_checks++;
      if (reads !== 9) begin n_fail++; $display("FAIL b2b_reads: got %0d expected 9", reads); end
      n_checks++;
      if (gap !== 1) begin n_fail++; $display("FAIL b2b_hdr_gap: got %0d expected 1", gap); end
   endtask

   initial begin
      test_reset();
      test_good_packet();
      test_parity_error();
      test_zero_len();
      test_timeout();
      test_sink_throttle();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
